// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake channel carrying a payload and a control field between pipeline stages.
// The master drives valid/data/ctrl, and the slave drives ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, a registered ready and a synchronous flush.
// Define PIPE_SKID_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
`ifdef PIPE_SKID_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  pipe_skid_reg_if.slave  up,
  pipe_skid_reg_if.master dn
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              ready_q;
  logic              accept;
  logic              consume;

  assign accept  = up.valid & ready_q;
  assign consume = main_valid & dn.ready;

  assign up.ready = ready_q;
  assign dn.valid = main_valid;
  assign dn.data  = main_data;
  assign dn.ctrl  = main_ctrl;

  // ready_q mirrors !skid_valid but is its own flop, so upstream never sees a combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      ready_q    <= 1'b1;
    end else if (clr) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state      <= ONE;
            main_valid <= 1'b1;
            main_data  <= up.data;
            main_ctrl  <= up.ctrl;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data <= up.data;
            main_ctrl <= up.ctrl;
          end else if (accept) begin
            state      <= FULL;
            skid_valid <= 1'b1;
            skid_data  <= up.data;
            skid_ctrl  <= up.ctrl;
            ready_q    <= 1'b0;
          end else if (consume) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= '0;
          end
        end
        FULL: begin
          if (consume) begin
            state      <= ONE;
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            ready_q    <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  // A flushed cycle is not a stall, even when the downstream stage was holding off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!clr && main_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: uses directed vector tables, async reset checks, and random traffic checked against a queue model.
// When PIPE_SKID_STALL_CNT_EN is defined, the bench also checks the stall counter with CNT_W=4.
module tb_pipe_skid_reg;
  localparam int DATA_W    = 32;
  localparam int CTRL_W    = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  typedef struct packed {
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;
    logic              clr;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic [CTRL_W-1:0] exp_ctrl;
    logic              exp_ready;
  } vec_t;

  logic clk;
  logic rst;
  logic clr;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  pipe_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
  pipe_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

  pipe_skid_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .up(up_if),
    .dn(dn_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of at most two entries plus the payload last seen at the output.
  entry_t            m_q[$];
  logic [DATA_W-1:0] m_last_data = '0;
  int                m_stall = 0;

  vec_t vecs[$];

  task automatic modelReset();
    m_q.delete();
    m_last_data = '0;
    m_stall = 0;
  endtask

  task automatic modelStep(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                           input logic r, input logic cl);
    entry_t e;
    bit can_take;
    if (cl) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && !r && m_stall < STALL_MAX) m_stall++;
      can_take = (m_q.size() < 2);
      if (m_q.size() > 0 && r) void'(m_q.pop_front());
      if (v && can_take) begin
        e.d = d;
        e.c = c;
        m_q.push_back(e);
      end
    end
    if (m_q.size() > 0) m_last_data = m_q[0].d;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [DATA_W-1:0] ed,
                             input logic [CTRL_W-1:0] ec, input logic er);
    checkField({name, ".out_valid"}, 32'(dn_if.valid), 32'(ev));
    checkField({name, ".out_data"},  32'(dn_if.data),  32'(ed));
    checkField({name, ".out_ctrl"},  32'(dn_if.ctrl),  32'(ec));
    checkField({name, ".in_ready"},  32'(up_if.ready), 32'(er));
`ifdef PIPE_SKID_STALL_CNT_EN
    checkField({name, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic checkModel(input string name);
    logic [CTRL_W-1:0] ec;
    ec = (m_q.size() > 0) ? m_q[0].c : '0;
    checkOutput(name, m_q.size() > 0, m_last_data, ec, m_q.size() < 2);
  endtask

  // Called on a falling edge; returns on the next falling edge once the model has seen the same rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                               input logic r, input logic cl);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = r;
    clr         = cl;
    @(posedge clk);
    modelStep(v, d, c, r, cl);
    @(negedge clk);
  endtask

  task automatic doReset();
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    clr         = 1'b0;
    rst         = 1'b1;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addVec(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic r, input logic cl, input logic ev, input logic [DATA_W-1:0] ed,
                        input logic [CTRL_W-1:0] ec, input logic er);
    vec_t x;
    x.in_valid = v;  x.in_data = d;   x.in_ctrl = c;   x.out_ready = r; x.clr = cl;
    x.exp_valid = ev; x.exp_data = ed; x.exp_ctrl = ec; x.exp_ready = er;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.ctrl  = '0;
    dn_if.ready = 1'b0;

    // Streaming: one entry per cycle, visible one cycle later.
    for (int i = 1; i <= 8; i++) addVec(1, i, 8'hA5, 1, 0, 1, i, 8'hA5, 1);
    addVec(0, 0, 0, 1, 0, 0, 32'h8, 8'h00, 1);
    // Backpressure into the skid entry, then drain in order.
    addVec(1, 32'h11, 8'h3C, 0, 0, 1, 32'h11, 8'h3C, 1);
    addVec(1, 32'h22, 8'h3C, 0, 0, 1, 32'h11, 8'h3C, 0);
    addVec(1, 32'h33, 8'h3C, 0, 0, 1, 32'h11, 8'h3C, 0);
    addVec(1, 32'h33, 8'h3C, 1, 0, 1, 32'h22, 8'h3C, 1);
    addVec(1, 32'h33, 8'h3C, 1, 0, 1, 32'h33, 8'h3C, 1);
    addVec(0, 0, 0, 1, 0, 0, 32'h33, 8'h00, 1);
    // Flush while FULL with 0x44 offered upstream.
    addVec(1, 32'h71, 8'h0F, 0, 0, 1, 32'h71, 8'h0F, 1);
    addVec(1, 32'h72, 8'h0F, 0, 0, 1, 32'h71, 8'h0F, 0);
    addVec(1, 32'h44, 8'hFF, 0, 1, 0, 32'h71, 8'h00, 1);
    addVec(0, 0, 0, 1, 0, 0, 32'h71, 8'h00, 1);
    // Accept and consume in the same cycle while ONE.
    addVec(1, 32'h55, 8'h5A, 0, 0, 1, 32'h55, 8'h5A, 1);
    addVec(1, 32'h66, 8'hC3, 1, 0, 1, 32'h66, 8'hC3, 1);
    addVec(0, 0, 0, 0, 0, 1, 32'h66, 8'hC3, 1);
    addVec(0, 0, 0, 1, 0, 0, 32'h66, 8'h00, 1);
    // An entry offered during a flush is dropped even from EMPTY.
    addVec(1, 32'h77, 8'h99, 1, 1, 0, 32'h66, 8'h00, 1);
    addVec(0, 0, 0, 1, 0, 0, 32'h66, 8'h00, 1);

    @(posedge clk);
    #1;
    checkOutput("reset_state", 0, 0, 0, 1);
    @(negedge clk);
    doReset();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl, vecs[i].out_ready, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ctrl,
                  vecs[i].exp_ready);
    end

    // Asynchronous reset with both entries occupied must take effect before any clock edge.
    applyStimulus(1, 32'h81, 8'h12, 0, 0);
    applyStimulus(1, 32'h82, 8'h34, 0, 0);
    checkOutput("full_before_rst", 1, 32'h81, 8'h12, 0);
    up_if.valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 0, 0, 0, 1);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("after_rst", 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      checkModel($sformatf("rand%0d", i));
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    doReset();
    applyStimulus(1, 32'h91, 8'h11, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
    checkField("stall_sat", 32'(stall_cnt), 32'd15);
    checkField("stall_sat_valid", 32'(dn_if.valid), 32'd1);
    doReset();
    applyStimulus(1, 32'h92, 8'h22, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkField("stall_pre_clr", 32'(stall_cnt), 32'd3);
    applyStimulus(0, 0, 0, 0, 1);
    checkField("stall_clr", 32'(stall_cnt), 32'd3);
    checkField("stall_clr_valid", 32'(dn_if.valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
